// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Control FSM for an ITER-bit non-restoring divider. Sequences the
//            external A/Q/M datapath through load, ITER shift/add-sub/set-bit
//            iterations, a final remainder correction and two output strobes
//            (quotient first, remainder second).
// Options  : DIV_CTRL_DBZ_EN - when defined, a CHK state after the divisor
//            load aborts divide-by-zero through ERR with a one-cycle err.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
  parameter int ITER = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic a_msb,
  input  logic m_zero,
  output logic ld_q,
  output logic ld_m,
  output logic clr_a,
  output logic shift_aq,
  output logic ld_sum,
  output logic sel_sub,
  output logic set_lsb,
  output logic q_lsb,
  output logic ld_out,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int              CW     = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD_Q  = 4'd1,
    S_LOAD_M  = 4'd2,
    S_SHIFT   = 4'd3,
    S_ADDSUB  = 4'd4,
    S_SETQ    = 4'd5,
    S_CORRECT = 4'd6,
    S_OUT_Q   = 4'd7,
    S_OUT_R   = 4'd8,
    S_DONE    = 4'd9
`ifdef DIV_CTRL_DBZ_EN
    ,
    S_CHK     = 4'd10,
    S_ERR     = 4'd11
`endif
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;

  // Registered strobes, each decoded from the state being entered
  logic r_ld_q, r_ld_m, r_clr_a, r_shift, r_sum_addsub, r_sel_sub;
  logic r_set_lsb, r_corr, r_ld_out, r_busy, r_done;
`ifdef DIV_CTRL_DBZ_EN
  logic r_err;
`endif

  // Next-state decode
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_nxt = S_LOAD_Q;
      S_LOAD_Q:  w_nxt = S_LOAD_M;
`ifdef DIV_CTRL_DBZ_EN
      S_LOAD_M:  w_nxt = S_CHK;
      S_CHK:     w_nxt = m_zero ? S_ERR : S_SHIFT;
      S_ERR:     w_nxt = S_IDLE;
`else
      S_LOAD_M:  w_nxt = S_SHIFT;
`endif
      S_SHIFT:   w_nxt = S_ADDSUB;
      S_ADDSUB:  w_nxt = S_SETQ;
      S_SETQ:    w_nxt = (r_cnt == C_LAST) ? S_CORRECT : S_SHIFT;
      S_CORRECT: w_nxt = S_OUT_Q;
      S_OUT_Q:   w_nxt = S_OUT_R;
      S_OUT_R:   w_nxt = S_DONE;
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // State, iteration counter, captured sign and registered Moore outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sign       <= 1'b0;
      r_ld_q       <= 1'b0;
      r_ld_m       <= 1'b0;
      r_clr_a      <= 1'b0;
      r_shift      <= 1'b0;
      r_sum_addsub <= 1'b0;
      r_sel_sub    <= 1'b0;
      r_set_lsb    <= 1'b0;
      r_corr       <= 1'b0;
      r_ld_out     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef DIV_CTRL_DBZ_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;

      case (r_state)
        S_LOAD_Q: begin
          r_cnt  <= '0;
          r_sign <= 1'b0;
        end
        // Sign before the shift decides subtract (A>=0) or add (A<0)
        S_SHIFT:  r_sign <= a_msb;
        S_SETQ:   r_cnt  <= (r_cnt == C_LAST) ? '0 : r_cnt + C_ONE;
        default:  ;
      endcase

      r_ld_q       <= (w_nxt == S_LOAD_Q);
      r_ld_m       <= (w_nxt == S_LOAD_M);
      r_clr_a      <= (w_nxt == S_LOAD_Q);
      r_shift      <= (w_nxt == S_SHIFT);
      r_sum_addsub <= (w_nxt == S_ADDSUB);
      // ADDSUB is only entered from SHIFT, where the sign register takes
      // a_msb on this same edge, so ~a_msb here equals ~sign during ADDSUB
      r_sel_sub    <= (w_nxt == S_ADDSUB) && !a_msb;
      r_set_lsb    <= (w_nxt == S_SETQ);
      r_corr       <= (w_nxt == S_CORRECT);
      r_ld_out     <= (w_nxt == S_OUT_Q) || (w_nxt == S_OUT_R);
      r_done       <= (w_nxt == S_DONE);
`ifdef DIV_CTRL_DBZ_EN
      r_busy       <= !(w_nxt inside {S_IDLE, S_DONE, S_ERR});
      r_err        <= (w_nxt == S_ERR);
`else
      r_busy       <= !(w_nxt inside {S_IDLE, S_DONE});
`endif
    end
  end

  // The quotient bit and the restore add depend on the live A sign, which
  // only settles inside SETQ/CORRECT, so they are gated rather than registered
  assign ld_q     = r_ld_q;
  assign ld_m     = r_ld_m;
  assign clr_a    = r_clr_a;
  assign shift_aq = r_shift;
  assign ld_sum   = r_sum_addsub | (r_corr & a_msb);
  assign sel_sub  = r_sel_sub;
  assign set_lsb  = r_set_lsb;
  assign q_lsb    = r_set_lsb & ~a_msb;
  assign ld_out   = r_ld_out;
  assign busy     = r_busy;
  assign done     = r_done;

`ifdef DIV_CTRL_DBZ_EN
  assign err = r_err;
`else
  logic w_unused_m_zero;
  assign w_unused_m_zero = m_zero;
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Purpose  : Self-checking bench for div_ctrl. A small A/Q/M datapath driven
//            by the controller strobes performs the division; results, strobe
//            timing and counts are compared with plain integer division and
//            the documented latency.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_ctrl;

  localparam int N = 8;
`ifdef DIV_CTRL_DBZ_EN
  localparam int LAT = 3*N + 7;
  localparam int SH1 = 4;
`else
  localparam int LAT = 3*N + 6;
  localparam int SH1 = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic a_msb, m_zero;
  logic ld_q, ld_m, clr_a, shift_aq, ld_sum, sel_sub;
  logic set_lsb, q_lsb, ld_out, busy, done, err;
  logic [11:0] outs;

  logic [N:0]   dp_a = '0;
  logic [N-1:0] dp_q = '0;
  logic [N-1:0] dp_m = '0;
  logic [N-1:0] host_dvd = '0;
  logic [N-1:0] host_dvs = '0;

  int n_checks = 0;
  int n_errors = 0;

  assign a_msb  = dp_a[N];
  assign m_zero = (dp_m == '0);
  assign outs   = {ld_q, ld_m, clr_a, shift_aq, ld_sum, sel_sub,
                   set_lsb, q_lsb, ld_out, busy, done, err};

  div_ctrl #(.ITER(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_msb(a_msb), .m_zero(m_zero),
    .ld_q(ld_q), .ld_m(ld_m), .clr_a(clr_a), .shift_aq(shift_aq),
    .ld_sum(ld_sum), .sel_sub(sel_sub), .set_lsb(set_lsb), .q_lsb(q_lsb),
    .ld_out(ld_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Divider datapath obeying the controller strobes
  always @(posedge clk) begin
    if (clr_a)         dp_a <= '0;
    else if (shift_aq) dp_a <= {dp_a[N-1:0], dp_q[N-1]};
    else if (ld_sum)   dp_a <= sel_sub ? dp_a - {1'b0, dp_m} : dp_a + {1'b0, dp_m};
    if (ld_q)          dp_q <= host_dvd;
    else if (shift_aq) dp_q <= {dp_q[N-2:0], 1'b0};
    else if (set_lsb)  dp_q[0] <= q_lsb;
    if (ld_m)          dp_m <= host_dvs;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One division from IDLE; noisy toggles start while the operation runs
  task automatic run_div(input logic [N-1:0] dvd, input logic [N-1:0] dvs, input bit noisy);
    int c_ldq = 0, c_out = 0, c_done = 0, c_err = 0, c_set = 0, c_sum = 0, c_bbad = 0;
    int ldq_at = -1, out1 = -1, out2 = -1, done_at = -1, err_at = -1;
    int span, end_cyc;
    bit dbz_abort;
    logic [N-1:0] qbits = '0, qcap = '0, rcap = '0, exp_q, exp_r;
    exp_q = (dvs == 0) ? '0 : dvd / dvs;
    exp_r = (dvs == 0) ? '0 : dvd % dvs;
`ifdef DIV_CTRL_DBZ_EN
    dbz_abort = (dvs == 0);
`else
    dbz_abort = 1'b0;
`endif
    end_cyc = dbz_abort ? 4 : LAT;
    span    = end_cyc + 2;
    host_dvd = dvd;
    host_dvs = dvs;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      if (ld_q)   begin c_ldq++; if (ldq_at < 0) ldq_at = k; end
      if (ld_out) begin
        c_out++;
        if (c_out == 1) begin out1 = k; qcap = dp_q; end
        else if (c_out == 2) begin out2 = k; rcap = dp_a[N-1:0]; end
      end
      if (done)   begin c_done++; if (done_at < 0) done_at = k; end
      if (err)    begin c_err++;  if (err_at < 0)  err_at = k;  end
      if (set_lsb) begin c_set++; qbits = {qbits[N-2:0], q_lsb}; end
      if (ld_sum) c_sum++;
      if (busy !== (k < end_cyc)) c_bbad++;
      start = (noisy && k < end_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    check_val($sformatf("ld_q cycle %0d/%0d", dvd, dvs), ldq_at, 1);
    check_val($sformatf("ld_q count %0d/%0d", dvd, dvs), c_ldq, 1);
    check_val($sformatf("busy window %0d/%0d", dvd, dvs), c_bbad, 0);
    if (dbz_abort) begin
      check_val("dbz err cycle", err_at, 4);
      check_val("dbz err count", c_err, 1);
      check_val("dbz ld_out count", c_out, 0);
      check_val("dbz done count", c_done, 0);
    end else begin
      check_val($sformatf("done cycle %0d/%0d", dvd, dvs), done_at, LAT);
      check_val($sformatf("done count %0d/%0d", dvd, dvs), c_done, 1);
      check_val($sformatf("err count %0d/%0d", dvd, dvs), c_err, 0);
      check_val($sformatf("ld_out count %0d/%0d", dvd, dvs), c_out, 2);
      check_val($sformatf("ld_out Q cycle %0d/%0d", dvd, dvs), out1, LAT - 2);
      check_val($sformatf("ld_out R cycle %0d/%0d", dvd, dvs), out2, LAT - 1);
      if (dvs != 0) begin
        check_val($sformatf("quotient %0d/%0d", dvd, dvs), qcap, exp_q);
        check_val($sformatf("remainder %0d/%0d", dvd, dvs), rcap, exp_r);
        check_val($sformatf("q_lsb bits %0d/%0d", dvd, dvs), qbits, exp_q);
        check_val($sformatf("set_lsb count %0d/%0d", dvd, dvs), c_set, N);
        // Final partial remainder is negative exactly when the last quotient
        // bit is 0, and only then does the correction add happen
        check_val($sformatf("ld_sum count %0d/%0d", dvd, dvs), c_sum, N + (exp_q[0] ? 0 : 1));
      end
    end
  endtask

  task automatic run_reset_abort();
    int c_bad = 0;
    host_dvd = 8'd100;
    host_dvs = 8'd7;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= SH1 + 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ld_out || done || err) c_bad++;
    end
    check_val("abort point is shift", shift_aq, 1);
    rst = 1'b0;
    @(negedge clk);
    check_val("abort outputs", outs, 0);
    check_val("abort early strobes", c_bad, 0);
    @(negedge clk);
    check_val("abort stays idle", outs, 0);
    rst = 1'b1;
  endtask

  task automatic run_start_held();
    int c_ldq = 0, c_done = 0, c_out = 0, exp_n = 0;
    logic [N-1:0] qcap = '0, rcap = '0;
    for (int e = 0; e <= 39; e += LAT + 1) exp_n++;
    host_dvd = 8'd200;
    host_dvs = 8'd9;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40 + LAT + 2; k++) begin
      @(negedge clk);
      if (ld_q) c_ldq++;
      if (done) c_done++;
      if (ld_out) begin
        if (c_out % 2 == 0) qcap = dp_q;
        else rcap = dp_a[N-1:0];
        c_out++;
      end
      start = (k < 40);
    end
    start = 1'b0;
    check_val("held start ld_q count", c_ldq, exp_n);
    check_val("held start done count", c_done, exp_n);
    check_val("held start quotient", qcap, 200 / 9);
    check_val("held start remainder", rcap, 200 % 9);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset outputs", outs, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle outputs", outs, 0);

    run_div(8'd100, 8'd7,   1'b0);
    run_div(8'd255, 8'd16,  1'b0);
    run_div(8'd7,   8'd9,   1'b0);
    run_div(8'd37,  8'd0,   1'b0);
    run_div(8'd255, 8'd1,   1'b0);
    run_div(8'd0,   8'd3,   1'b0);
    run_div(8'd255, 8'd255, 1'b0);
    run_div(8'd128, 8'd128, 1'b1);
    for (int i = 0; i < 15; i++)
      run_div(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b1);

    run_reset_abort();
    run_div(8'd100, 8'd7, 1'b0);
    run_start_held();
    run_div(8'd61, 8'd5, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
